uart_tx_serializer: RTL and testbench

- Transmit-side consumer of the UART TX FIFO.
- Pops one character at a time from the FIFO read port and serializes it onto txd.
- Frames each character as: start bit, 5-8 data bits LSB first, optional parity, then 1, 1.5 or 2 stop bits.
- Line-control fields follow the 16550 LCR definitions.
- Bit timing is derived from the 16x-oversample baud_tick produced by the baud generator.

---
 rtl/uart_tx_serializer.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Transmit side of the UART: pops characters from the TX FIFO one at a time
// and shifts them onto txd as start bit, 5-8 data bits (LSB first), optional
// parity and 1 / 1.5 / 2 stop bits. Line-control inputs use the 16550 LCR
// encoding. Bit timing comes from a 16x (OVERSAMPLE) baud_tick strobe.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   baud_tick           one-clk strobe, OVERSAMPLE per bit period
//   word_len            LCR[1:0]: 0..3 -> 5..8 data bits
//   stop_bits           LCR[2]:   0 -> 1 stop, 1 -> 1.5 (5-bit) or 2 stop
//   parity_en           LCR[3]
//   even_parity         LCR[4]
//   stick_parity        LCR[5]
//   break_ctrl          LCR[6]: holds txd low (FSM keeps running)
//   fifo_empty          FIFO empty flag
//   fifo_rd_en          one-clk pop request
//   fifo_rd_data/valid  FIFO read data, valid one clk after fifo_rd_en
//   txd                 serial line, idle high (registered)
//   tx_busy             FSM not idle (registered)
//   temt                transmitter empty: idle and FIFO empty (combinational)
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int WIDTH      = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             baud_tick,
    input  logic [1:0]       word_len,
    input  logic             stop_bits,
    input  logic             parity_en,
    input  logic             even_parity,
    input  logic             stick_parity,
    input  logic             break_ctrl,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             fifo_rd_valid,
    output logic             txd,
    output logic             tx_busy,
    output logic             temt
);

    // Tick counter must reach the longest period: two stop bits.
    localparam int TW = $clog2(2 * OVERSAMPLE + 1);

    localparam logic [TW-1:0] BIT_TICKS    = TW'(OVERSAMPLE);
    localparam logic [TW-1:0] STOP1_TICKS  = TW'(OVERSAMPLE);
    localparam logic [TW-1:0] STOP15_TICKS = TW'(OVERSAMPLE + OVERSAMPLE / 2);
    localparam logic [TW-1:0] STOP2_TICKS  = TW'(2 * OVERSAMPLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e          state_q,      state_d;
    logic [TW-1:0]   tick_cnt_q,   tick_cnt_d;
    logic [2:0]      bit_cnt_q,    bit_cnt_d;
    logic [7:0]      shreg_q,      shreg_d;
    // Frame format is captured in already-decoded form at fetch time so the
    // whole frame is immune to LCR writes made while it is on the line.
    logic [2:0]      last_bit_q,   last_bit_d;
    logic            parity_en_q,  parity_en_d;
    logic            parity_bit_q, parity_bit_d;
    logic [TW-1:0]   stop_ticks_q, stop_ticks_d;
    logic            txd_q,        txd_d;
    logic            rd_en_q,      rd_en_d;
    logic            busy_q,       busy_d;

    logic [7:0]      rd_byte;
    logic [7:0]      data_mask;
    logic [TW-1:0]   period;
    logic            bit_end;
    logic            line;

    assign rd_byte   = fifo_rd_data[7:0];
    // Only the transmitted data bits take part in the parity calculation.
    assign data_mask = 8'hFF >> (2'd3 - word_len);

    // Length of the current bit period in ticks; STOP is the only variable one.
    assign period  = (state_q == S_STOP) ? stop_ticks_q : BIT_TICKS;
    assign bit_end = baud_tick && (tick_cnt_q == period - TW'(1));

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        last_bit_d   = last_bit_q;
        parity_en_d  = parity_en_q;
        parity_bit_d = parity_bit_q;
        stop_ticks_d = stop_ticks_q;
        rd_en_d      = 1'b0;
        line         = 1'b1;

        // Ticks are only counted inside bit states; a completed period
        // restarts the count for the next bit.
        if (state_q != S_IDLE && state_q != S_FETCH && baud_tick) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    rd_en_d = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                if (fifo_rd_valid) begin
                    shreg_d     = rd_byte;
                    last_bit_d  = {1'b0, word_len} + 3'd4;
                    parity_en_d = parity_en;
                    if (stick_parity) begin
                        parity_bit_d = ~even_parity;
                    end else begin
                        parity_bit_d = (^(rd_byte & data_mask)) ^ ~even_parity;
                    end
                    if (!stop_bits) begin
                        stop_ticks_d = STOP1_TICKS;
                    end else if (word_len == 2'd0) begin
                        stop_ticks_d = STOP15_TICKS;
                    end else begin
                        stop_ticks_d = STOP2_TICKS;
                    end
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = S_START;
                end
            end

            S_START: begin
                line = 1'b0;
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                line = shreg_q[0];
                if (bit_end) begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == last_bit_q) begin
                        state_d = parity_en_q ? S_PARITY : S_STOP;
                    end
                end
            end

            S_PARITY: begin
                line = parity_bit_q;
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                line = 1'b1;
                if (bit_end) begin
                    // Chain straight into the next character when one waits.
                    if (!fifo_empty) begin
                        rd_en_d = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // txd lags the state by one clk; break overrides whatever the FSM drives.
        txd_d  = break_ctrl ? 1'b0 : line;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            last_bit_q   <= '0;
            parity_en_q  <= 1'b0;
            parity_bit_q <= 1'b0;
            stop_ticks_q <= STOP1_TICKS;
            txd_q        <= 1'b1;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            last_bit_q   <= last_bit_d;
            parity_en_q  <= parity_en_d;
            parity_bit_q <= parity_bit_d;
            stop_ticks_q <= stop_ticks_d;
            txd_q        <= txd_d;
            rd_en_q      <= rd_en_d;
            busy_q       <= busy_d;
        end
    end

    assign txd        = txd_q;
    assign fifo_rd_en = rd_en_q;
    assign tx_busy    = busy_q;
    assign temt       = (state_q == S_IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Directed + randomized bench. A simple FIFO model feeds the DUT; txd,
// tx_busy and temt are sampled every falling edge into queues. Expected line
// waveforms are built per clk from the frame format rules (start, data LSB
// first, parity by counting ones, stop length) with one tick per clk.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int OS    = 16;
    localparam int PAUSE = 50;
    localparam int BRK   = 40;

    logic       clk          = 1'b0;
    logic       rst          = 1'b0;
    logic       baud_tick    = 1'b1;
    logic [1:0] word_len     = 2'd3;
    logic       stop_bits    = 1'b0;
    logic       parity_en    = 1'b0;
    logic       even_parity  = 1'b0;
    logic       stick_parity = 1'b0;
    logic       break_ctrl   = 1'b0;
    logic       fifo_empty   = 1'b1;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_rd_valid = 1'b0;
    logic       txd;
    logic       tx_busy;
    logic       temt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.WIDTH(8), .OVERSAMPLE(OS)) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_tick     (baud_tick),
        .word_len      (word_len),
        .stop_bits     (stop_bits),
        .parity_en     (parity_en),
        .even_parity   (even_parity),
        .stick_parity  (stick_parity),
        .break_ctrl    (break_ctrl),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_valid (fifo_rd_valid),
        .txd           (txd),
        .tx_busy       (tx_busy),
        .temt          (temt)
    );

    // FIFO model: the initial block writes entries, this block pops them.
    logic [7:0] fmem [0:255];
    int wr_ptr   = 0;
    int rd_ptr   = 0;
    int rd_cnt   = 0;
    int empty_rd = 0;

    always @(posedge clk) begin
        fifo_rd_valid <= 1'b0;
        if (fifo_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (fifo_empty) begin
                empty_rd   <= empty_rd + 1;
                fifo_empty <= (rd_ptr == wr_ptr);
            end else begin
                fifo_rd_data  <= fmem[rd_ptr % 256];
                fifo_rd_valid <= 1'b1;
                rd_ptr        <= rd_ptr + 1;
                fifo_empty    <= (rd_ptr + 1 == wr_ptr);
            end
        end else begin
            fifo_empty <= (rd_ptr == wr_ptr);
        end
    end

    logic cap_txd[$];
    logic cap_busy[$];
    logic cap_temt[$];

    always @(negedge clk) begin
        cap_txd.push_back(txd);
        cap_busy.push_back(tx_busy);
        cap_temt.push_back(temt);
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    logic       exp_q[$];
    logic [7:0] chars[$];
    int         last_i0 = 0;

    // One frame, one clk per tick, under the current LCR inputs.
    task automatic add_frame(input logic [7:0] d);
        int   nb;
        int   ones;
        int   stop_len;
        logic p;
        nb   = int'(word_len) + 5;
        ones = 0;
        repeat (OS) exp_q.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            repeat (OS) exp_q.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (parity_en) begin
            if (stick_parity) p = ~even_parity;
            else if (even_parity) p = ((ones % 2) == 1);
            else p = ((ones % 2) == 0);
            repeat (OS) exp_q.push_back(p);
        end
        if (!stop_bits) stop_len = OS;
        else if (word_len == 2'd0) stop_len = OS * 3 / 2;
        else stop_len = 2 * OS;
        repeat (stop_len) exp_q.push_back(1'b1);
    endtask

    task automatic rand_lcr();
        word_len     = 2'($urandom_range(3, 0));
        stop_bits    = 1'($urandom_range(1, 0));
        parity_en    = 1'($urandom_range(1, 0));
        even_parity  = 1'($urandom_range(1, 0));
        stick_parity = 1'($urandom_range(1, 0));
    endtask

    task automatic set_lcr(input int wl, input int sb, input int pe, input int ep, input int sp);
        word_len     = 2'(wl);
        stop_bits    = 1'(sb);
        parity_en    = 1'(pe);
        even_parity  = 1'(ep);
        stick_parity = 1'(sp);
    endtask

    // Send chars[] and compare the line against the model. pause_at/brk_at
    // are clk offsets from the push (0 = unused); scramble rewrites LCR mid-frame.
    task automatic run(input int pause_at, input int brk_at, input bit scramble);
        int base, i0, bad, len, bf, tr, rd0, total, brk_on, brk_off;
        exp_q.delete();
        foreach (chars[c]) begin
            if (c > 0) begin
                exp_q.push_back(1'b1);
                exp_q.push_back(1'b1);
            end
            add_frame(chars[c]);
        end
        // Ticks withheld inside data bit 2 just stretch that bit.
        if (pause_at > 0) begin
            for (int k = 0; k < PAUSE; k++) exp_q.insert(3 * OS + 8, exp_q[3 * OS + 8]);
        end
        len = exp_q.size();
        repeat (8) exp_q.push_back(1'b1);
        rd0     = rd_cnt;
        brk_on  = -1;
        brk_off = -1;
        step();
        foreach (chars[c]) begin
            fmem[wr_ptr % 256] = chars[c];
            wr_ptr++;
        end
        base  = cap_txd.size();
        total = exp_q.size() + 60;
        for (int t = 1; t <= total; t++) begin
            step();
            if (scramble && t == 20) rand_lcr();
            if (pause_at > 0 && t == pause_at) baud_tick = 1'b0;
            if (pause_at > 0 && t == pause_at + PAUSE) baud_tick = 1'b1;
            if (brk_at > 0 && t == brk_at) begin
                break_ctrl = 1'b1;
                brk_on     = cap_txd.size();
            end
            if (brk_at > 0 && t == brk_at + BRK) begin
                break_ctrl = 1'b0;
                brk_off    = cap_txd.size();
            end
        end
        i0 = -1;
        for (int i = base; i < cap_txd.size(); i++) begin
            if (i0 < 0 && cap_txd[i] === 1'b0) i0 = i;
        end
        chk("start_bit_seen", 32'(i0 >= 0), 1);
        if (i0 < 0) return;
        last_i0 = i0;
        if (brk_on >= 0) begin
            for (int i = brk_on; i < brk_off; i++) begin
                if (i - i0 >= 0 && i - i0 < exp_q.size()) exp_q[i - i0] = 1'b0;
            end
        end
        bad = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (bad < 0 && (i0 + k >= cap_txd.size() || cap_txd[i0 + k] !== exp_q[k])) bad = k;
        end
        chk("txd_first_bad_index", bad, -1);
        // txd lags the state by one clk, so the FSM reaches IDLE len-1 samples
        // after the first low txd sample.
        bf = -1;
        tr = -1;
        for (int i = i0; i < cap_busy.size(); i++) begin
            if (bf < 0 && cap_busy[i] !== 1'b1) bf = i - i0;
            if (tr < 0 && cap_temt[i] === 1'b1) tr = i - i0;
        end
        chk("busy_fall_offset", bf, len - 1);
        chk("temt_rise_offset", tr, len - 1);
        chk("rd_en_pulses", rd_cnt - rd0, chars.size());
        chk("rd_en_while_empty", empty_rd, 0);
    endtask

    initial begin
        int rd0, ones_after;

        // Reset state
        repeat (3) step();
        chk("reset_txd", 32'(txd), 1);
        chk("reset_busy", 32'(tx_busy), 0);
        chk("reset_rd_en", 32'(fifo_rd_en), 0);
        chk("reset_temt", 32'(temt), 1);
        rst = 1'b1;
        repeat (2) step();

        // 0x55, 8N1: alternating bits, 16 clks each
        set_lcr(3, 0, 0, 0, 0);
        chars = '{8'h55};
        run(0, 0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            chk("t55_bit_center", 32'(cap_txd[last_i0 + OS * k + 8]), k % 2);
        end

        // Parity on 0x03 (two ones)
        set_lcr(3, 0, 1, 1, 0);
        chars = '{8'h03};
        run(0, 0, 1'b0);
        chk("even_parity_bit", 32'(cap_txd[last_i0 + OS * 9 + 8]), 0);
        set_lcr(3, 0, 1, 0, 0);
        run(0, 0, 1'b0);
        chk("odd_parity_bit", 32'(cap_txd[last_i0 + OS * 9 + 8]), 1);
        set_lcr(3, 0, 1, 1, 1);
        run(0, 0, 1'b0);
        chk("stick_parity_bit", 32'(cap_txd[last_i0 + OS * 9 + 8]), 0);
        chars = '{8'h01};
        run(0, 0, 1'b0);
        chk("stick_parity_bit_odd_data", 32'(cap_txd[last_i0 + OS * 9 + 8]), 0);

        // Stop lengths: 1.5 stop with 5 bits, 2 stop with 8 bits
        set_lcr(0, 1, 0, 0, 0);
        chars = '{8'h1F};
        run(0, 0, 1'b0);
        set_lcr(3, 1, 0, 0, 0);
        chars = '{8'h81};
        run(0, 0, 1'b0);

        // Back-to-back characters
        set_lcr(3, 0, 0, 0, 0);
        chars = '{8'hA5, 8'h00, 8'hFF};
        run(0, 0, 1'b0);

        // Break mid-data
        chars = '{8'h55};
        run(0, 60, 1'b0);

        // Withheld baud ticks stretch the bit
        chars = '{8'($urandom)};
        run(58, 0, 1'b0);

        // Random single frames, LCR rewritten mid-frame
        repeat (10) begin
            rand_lcr();
            chars = '{8'($urandom)};
            run(($urandom_range(1, 0) == 1) ? 58 : 0, 0, 1'b1);
        end

        // Random back-to-back pairs
        repeat (3) begin
            rand_lcr();
            chars = '{8'($urandom), 8'($urandom)};
            run(0, 0, 1'b0);
        end

        // Reset during DATA
        set_lcr(3, 0, 0, 0, 0);
        rd0 = rd_cnt;
        step();
        fmem[wr_ptr % 256] = 8'h5A;
        wr_ptr++;
        repeat (60) step();
        rst = 1'b0;
        #1;
        chk("midreset_txd", 32'(txd), 1);
        chk("midreset_busy", 32'(tx_busy), 0);
        chk("midreset_rd_en", 32'(fifo_rd_en), 0);
        repeat (3) step();
        rst = 1'b1;
        repeat (40) step();
        ones_after = 0;
        for (int i = cap_txd.size() - 40; i < cap_txd.size(); i++) begin
            if (cap_txd[i] === 1'b1) ones_after++;
        end
        chk("post_reset_txd_idle", ones_after, 40);
        chk("post_reset_rd_en_pulses", rd_cnt - rd0, 1);
        chk("post_reset_temt", 32'(temt), 1);
        chk("post_reset_busy", 32'(tx_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
